// File: rtl/sound_pkg.sv
// -----------------------------------------------------------------------------
// sound_pkg
//   Shared types and constants for the sound event scheduler.
//   - snd_state_t : scheduler FSM states (also exported on the debug port)
//   - tone_id_t   : tone index type for the default four-requester build
//   - SND_REQ_*   : requester index assignment (0 = highest priority)
//   - snd_max     : elaboration-time helper for sizing the frame counter
// -----------------------------------------------------------------------------
package sound_pkg;

   localparam int SND_NUM_REQ        = 4;

   localparam int SND_REQ_ENEMY_HIT  = 0;
   localparam int SND_REQ_PLAYER_HIT = 1;
   localparam int SND_REQ_BOSS_HIT   = 2;
   localparam int SND_REQ_POWERUP    = 3;

   typedef enum logic [1:0] {
      SND_IDLE = 2'd0,
      SND_PLAY = 2'd1,
      SND_GAP  = 2'd2
   } snd_state_t;

   typedef logic [$clog2(SND_NUM_REQ)-1:0] tone_id_t;

   function automatic int snd_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/fixed_priority_arbiter.sv
// -----------------------------------------------------------------------------
// fixed_priority_arbiter
//   Purely combinational fixed-priority picker; bit 0 has the highest priority.
//   Ports:
//     req_i          [N]          request vector
//     grant_onehot_o [N]          one-hot of the lowest set request (0 if none)
//     grant_idx_o    [clog2(N)]   index of the lowest set request (0 if none)
//     any_o                       at least one request is set
// -----------------------------------------------------------------------------
module fixed_priority_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_i,
   output logic [N-1:0]         grant_onehot_o,
   output logic [$clog2(N)-1:0] grant_idx_o,
   output logic                 any_o
);

   localparam int IW = $clog2(N);

   always_comb begin
      // Two's-complement trick isolates the lowest set bit.
      grant_onehot_o = req_i & (~req_i + N'(1));
      grant_idx_o    = '0;
      // Walk from the top down so the lowest set index is written last.
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            grant_idx_o = IW'(i);
         end
      end
      any_o = |req_i;
   end

endmodule

// File: rtl/sound_scheduler.sv
// -----------------------------------------------------------------------------
// sound_scheduler
//   Sequences one-cycle game sound events onto the single tone generator.
//   Event pulses are latched as pending requests, granted one at a time by
//   fixed priority (index 0 highest), each granted tone is held for
//   TONE_FRAMES frames followed by GAP_FRAMES silent frames. No preemption.
//
//   Ports:
//     clk            system clock
//     rst            asynchronous active-high reset
//     startOfFrame   one-cycle pulse per video frame
//     enable         0 = paused: counter/state frozen, output muted, no grants
//     sound_req      one-cycle event pulses, bit i = requester i
//     tone_valid     tone generator must sound tone_id (registered)
//     tone_id        index of the most recently granted requester
//     tone_start     one-cycle pulse on every grant
//     busy           FSM is not idle
//     pending        latched, not-yet-granted requests
//     dbg_state      current FSM state, for observation only
//
//   Handshake: there is no back-pressure. tone_start acts as a one-cycle valid
//   that qualifies a new tone_id; tone_valid is a level meaning "sound now".
//   The consumer has no ready and must accept every grant.
// -----------------------------------------------------------------------------
module sound_scheduler
   import sound_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int TONE_FRAMES = 8,
   parameter int GAP_FRAMES  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       startOfFrame,
   input  logic                       enable,
   input  logic [NUM_REQ-1:0]         sound_req,
   output logic                       tone_valid,
   output logic [$clog2(NUM_REQ)-1:0] tone_id,
   output logic                       tone_start,
   output logic                       busy,
   output logic [NUM_REQ-1:0]         pending,
   output snd_state_t                 dbg_state
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(snd_max(TONE_FRAMES, GAP_FRAMES) + 1);

   localparam logic [CW-1:0] TONE_LOAD = CW'(TONE_FRAMES);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_FRAMES);

   snd_state_t         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic [IW-1:0]      tone_id_q, tone_id_d;
   logic               tone_valid_q, tone_valid_d;
   logic               tone_start_q, tone_start_d;

   logic [NUM_REQ-1:0] arb_onehot;
   logic [IW-1:0]      arb_idx;
   logic               arb_any;
   logic               grant;
   logic               tick;

   fixed_priority_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .req_i          (pending_q),
      .grant_onehot_o (arb_onehot),
      .grant_idx_o    (arb_idx),
      .any_o          (arb_any)
   );

   // Frame ticks only count while running; a paused scheduler holds its place.
   assign tick = startOfFrame & enable;

   // Next-state logic. The counter is only touched when it is above 1, so it
   // can never wrap; reaching the last frame moves the FSM on instead.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant   = 1'b0;

      unique case (state_q)
         SND_IDLE: begin
            if (enable && arb_any) begin
               grant   = 1'b1;
               state_d = SND_PLAY;
               cnt_d   = TONE_LOAD;
            end
         end

         SND_PLAY: begin
            if (tick) begin
               if (cnt_q <= CW'(1)) begin
                  if (GAP_FRAMES == 0) begin
                     state_d = SND_IDLE;
                     cnt_d   = '0;
                  end else begin
                     state_d = SND_GAP;
                     cnt_d   = GAP_LOAD;
                  end
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end

         SND_GAP: begin
            if (tick) begin
               if (cnt_q <= CW'(1)) begin
                  state_d = SND_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end

         default: begin
            state_d = SND_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Datapath next values. A request arriving in the same cycle its bit is
   // granted is OR-ed in after the clear, so it survives and replays later.
   always_comb begin
      pending_d    = (pending_q & ~(grant ? arb_onehot : '0)) | sound_req;
      tone_id_d    = grant ? arb_idx : tone_id_q;
      tone_start_d = grant;
      tone_valid_d = (state_d == SND_PLAY) && enable;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= SND_IDLE;
         cnt_q        <= '0;
         pending_q    <= '0;
         tone_id_q    <= '0;
         tone_valid_q <= 1'b0;
         tone_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         tone_id_q    <= tone_id_d;
         tone_valid_q <= tone_valid_d;
         tone_start_q <= tone_start_d;
      end
   end

   assign tone_valid = tone_valid_q;
   assign tone_id    = tone_id_q;
   assign tone_start = tone_start_q;
   assign busy       = (state_q != SND_IDLE);
   assign pending    = pending_q;
   assign dbg_state  = state_q;

endmodule
